// File: rtl/xbar_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_burst_arbiter
//  Purpose  : Round-robin arbiter for one crossbar slave port shared by four
//             masters. A grant is held for a whole burst. It is released on
//             the granted master's last-beat handshake, when that master
//             withdraws its request, or when a watchdog detects a stalled
//             burst.
//  Ports    :
//    iClk         in   1  clock
//    iRst_n       in   1  asynchronous active-low reset
//    iReq         in   4  per-master request, held high for the whole burst
//    iValid       in   4  per-master beat valid
//    iLast        in   4  per-master last-beat flag, qualified by iValid
//    iReady       in   1  slave beat ready
//    oGrant       out  2  index of granted master, stable while oGrantValid
//    oGrantValid  out  1  grant active (BUSY)
//    oBeat        out  1  beat handshake of the granted master
//    oTimeout     out  1  one-cycle pulse on watchdog release
//    oTimeoutMst  out  2  master released by the most recent timeout
//  Revision : 1.0  initial release
// ============================================================================
module xbar_burst_arbiter #(
  parameter int unsigned TO_CYC = 256  // stalled BUSY cycles before forced release; 0 disables
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [3:0] iReq,
  input  logic [3:0] iValid,
  input  logic [3:0] iLast,
  input  logic       iReady,
  output logic [1:0] oGrant,
  output logic       oGrantValid,
  output logic       oBeat,
  output logic       oTimeout,
  output logic [1:0] oTimeoutMst
);

  // A disabled watchdog still keeps a 1-bit counter so no zero-width vector
  // is ever declared.
  localparam int unsigned CW         = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam int unsigned C_LAST_INT = (TO_CYC > 0) ? (TO_CYC - 1) : 0;
  localparam logic [CW-1:0] C_CNT_LAST = C_LAST_INT[CW-1:0];
  localparam logic [CW-1:0] C_CNT_MAX  = '1;
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam bit            C_TO_EN    = (TO_CYC != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic [1:0]    to_mst_q, to_mst_d;

  logic [1:0]    winner;
  logic          beat;

  // Round-robin search. It starts just after the last released master, so
  // that master has the lowest priority. It is still chosen when it is the
  // only requester.
  always_comb begin : arb_search
    logic found;
    winner = ptr_q + 2'd1;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && iReq[ptr_q + 2'(k)]) begin
        winner = ptr_q + 2'(k);
        found  = 1'b1;
      end
    end
  end

  // Only the granted master's valid is looked at, and only in BUSY.
  assign beat = (state_q == ST_BUSY) & iValid[grant_q] & iReady;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    to_d     = 1'b0;
    to_mst_d = to_mst_q;

    case (state_q)
      ST_IDLE: begin
        // Requests that arrive in the same cycle as a release are
        // arbitrated here. This gives exactly one bubble between grants.
        if (|iReq) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (beat && iLast[grant_q]) begin
          state_d = ST_IDLE;
          ptr_d   = grant_q;
        end else if (!iReq[grant_q]) begin
          state_d = ST_IDLE;
          ptr_d   = grant_q;
        end else if (C_TO_EN && !beat && (cnt_q == C_CNT_LAST)) begin
          // A beat in the final watchdog cycle takes precedence and
          // restarts the count.
          state_d  = ST_IDLE;
          ptr_d    = grant_q;
          to_d     = 1'b1;
          to_mst_d = grant_q;
        end else if (beat) begin
          cnt_d = '0;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // On reset the pointer is set to 3, so master 0 wins the first arbitration.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'd0;
      ptr_q    <= 2'd3;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      to_mst_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      to_mst_q <= to_mst_d;
    end
  end

  assign oGrant      = grant_q;
  assign oGrantValid = (state_q == ST_BUSY);
  assign oBeat       = beat;
  assign oTimeout    = to_q;
  assign oTimeoutMst = to_mst_q;

endmodule
`default_nettype wire
